// File: rtl/conv_seq.sv
// conv_seq: frame sequencer for a column-streaming N x N convolution engine.
// It walks a frame through FILL (N+1 columns), then alternates
// PROC -> OUT -> LOAD until i_ncols-N output columns have been produced.
// The phase code {o_eop,o_sop} and the o_chblk column-change pulse drive a
// memory control unit that rotates N+2 column banks.
// Optional feature: define CONV_SEQ_ABORT_EN to add i_abort / o_abort_ack.
// NB_ADDR must be wide enough to hold IMG_H-1 (2**NB_ADDR >= IMG_H).
module conv_seq #(
   parameter int N        = 2,
   parameter int IMG_H    = 440,
   parameter int NB_ADDR  = 9,
   parameter int NB_COL   = 10,
   parameter int PROC_LAT = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_start,
   input  logic [NB_COL-1:0]  i_ncols,
   input  logic               i_valid,
   input  logic               i_out_ready,
   output logic               o_sop,
   output logic               o_eop,
   output logic               o_chblk,
   output logic [NB_ADDR-1:0] o_addr,
   output logic               o_in_ready,
   output logic               o_out_valid,
   output logic [NB_COL-1:0]  o_col_cnt,
   output logic               o_busy,
   output logic               o_done
`ifdef CONV_SEQ_ABORT_EN
   ,
   input  logic               i_abort,
   output logic               o_abort_ack
`endif
);

   // PROC runs for a full column sweep plus the drain allowance of the datapath.
   localparam int PROC_LEN = IMG_H + PROC_LAT;
   localparam int CNT_W    = $clog2(PROC_LEN + 1);
   localparam int COL_W    = $clog2(N + 2);

   localparam logic [NB_ADDR-1:0] ADDR_LAST = NB_ADDR'(IMG_H - 1);
   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(PROC_LEN - 1);
   localparam logic [COL_W-1:0]   FILL_LAST = COL_W'(N);
   localparam logic [NB_COL-1:0]  NCOLS_MIN = NB_COL'(N + 1);
   localparam logic [NB_COL-1:0]  N_NCOL    = NB_COL'(N);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_FILL = 3'd1,
      S_PROC = 3'd2,
      S_OUT  = 3'd3,
      S_LOAD = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t               state_q, state_d;
   logic [NB_ADDR-1:0]   addr_q, addr_d;
   logic [COL_W-1:0]     fill_col_q, fill_col_d;
   logic [CNT_W-1:0]     proc_cnt_q, proc_cnt_d;
   logic [NB_COL-1:0]    col_cnt_q, col_cnt_d;
   logic [NB_COL-1:0]    ncols_q, ncols_d;
   logic                 chblk_q, chblk_d;
   logic                 in_ready_q, in_ready_d;
   logic                 out_valid_q, out_valid_d;
   logic                 sop_q, sop_d;
   logic                 eop_q, eop_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic                 accept;
   logic                 xfer;
   logic                 abort_hit;

   // Handshakes are qualified by registered readiness, so i_valid and
   // i_out_ready are naturally ignored outside the phases that use them.
   assign accept = i_valid & in_ready_q;
   assign xfer   = out_valid_q & i_out_ready;

`ifdef CONV_SEQ_ABORT_EN
   logic abort_ack_q, abort_ack_d;

   assign abort_hit   = i_abort & (state_q != S_IDLE);
   assign o_abort_ack = abort_ack_q;
`else
   assign abort_hit = 1'b0;
`endif

   // Next-state, counter and registered-output computation.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      fill_col_d = fill_col_q;
      proc_cnt_d = proc_cnt_q;
      col_cnt_d  = col_cnt_q;
      ncols_d    = ncols_q;
      chblk_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               ncols_d    = i_ncols;
               col_cnt_d  = '0;
               addr_d     = '0;
               fill_col_d = '0;
               proc_cnt_d = '0;
               // Too few columns for even one output: finish without touching memory.
               state_d    = (i_ncols >= NCOLS_MIN) ? S_FILL : S_DONE;
            end
         end

         S_FILL: begin
            // The o_chblk cycle has in_ready low, so accept is 0 there and
            // the pulse drops back after exactly one cycle.
            if (accept) begin
               if (addr_q == ADDR_LAST) begin
                  addr_d = '0;
                  if (fill_col_q == FILL_LAST) begin
                     fill_col_d = '0;
                     proc_cnt_d = '0;
                     state_d    = S_PROC;
                  end else begin
                     fill_col_d = fill_col_q + COL_W'(1);
                     chblk_d    = 1'b1;
                  end
               end else begin
                  addr_d = addr_q + NB_ADDR'(1);
               end
            end
         end

         S_LOAD: begin
            if (accept) begin
               if (addr_q == ADDR_LAST) begin
                  addr_d     = '0;
                  proc_cnt_d = '0;
                  state_d    = S_PROC;
               end else begin
                  addr_d = addr_q + NB_ADDR'(1);
               end
            end
         end

         S_PROC: begin
            if (proc_cnt_q == CNT_LAST) begin
               addr_d     = '0;
               proc_cnt_d = '0;
               state_d    = S_OUT;
            end else begin
               proc_cnt_d = proc_cnt_q + CNT_W'(1);
               // Sweep the column once, then park on the last row while the
               // pipeline drains.
               if (addr_q != ADDR_LAST) begin
                  addr_d = addr_q + NB_ADDR'(1);
               end
            end
         end

         S_OUT: begin
            if (xfer) begin
               if (addr_q == ADDR_LAST) begin
                  addr_d    = '0;
                  col_cnt_d = col_cnt_q + NB_COL'(1);
                  state_d   = (col_cnt_d == (ncols_q - N_NCOL)) ? S_DONE : S_LOAD;
               end else begin
                  addr_d = addr_q + NB_ADDR'(1);
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort wins over everything and leaves a clean IDLE behind it.
      if (abort_hit) begin
         state_d    = S_IDLE;
         addr_d     = '0;
         fill_col_d = '0;
         proc_cnt_d = '0;
         col_cnt_d  = '0;
         ncols_d    = '0;
         chblk_d    = 1'b0;
      end

      // Outputs are flops whose values track the state being entered, so the
      // visible phase, readiness and valid always match the current state.
      in_ready_d  = ((state_d == S_FILL) || (state_d == S_LOAD)) && !chblk_d;
      out_valid_d = (state_d == S_OUT);
      sop_d       = (state_d == S_PROC);
      eop_d       = (state_d == S_OUT);
      busy_d      = (state_d != S_IDLE);
      // The end-of-frame pulse is issued as the DONE state is left.
      done_d      = (state_q == S_DONE) && !abort_hit;
`ifdef CONV_SEQ_ABORT_EN
      abort_ack_d = abort_hit;
`endif
   end

   // State, counters and output registers; reset drops any frame in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         fill_col_q  <= '0;
         proc_cnt_q  <= '0;
         col_cnt_q   <= '0;
         ncols_q     <= '0;
         chblk_q     <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         sop_q       <= 1'b0;
         eop_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef CONV_SEQ_ABORT_EN
         abort_ack_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         fill_col_q  <= fill_col_d;
         proc_cnt_q  <= proc_cnt_d;
         col_cnt_q   <= col_cnt_d;
         ncols_q     <= ncols_d;
         chblk_q     <= chblk_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         sop_q       <= sop_d;
         eop_q       <= eop_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef CONV_SEQ_ABORT_EN
         abort_ack_q <= abort_ack_d;
`endif
      end
   end

   assign o_sop       = sop_q;
   assign o_eop       = eop_q;
   assign o_chblk     = chblk_q;
   assign o_addr      = addr_q;
   assign o_in_ready  = in_ready_q;
   assign o_out_valid = out_valid_q;
   assign o_col_cnt   = col_cnt_q;
   assign o_busy      = busy_q;
   assign o_done      = done_q;

endmodule

// File: tb/tb_conv_seq.sv
// tb_conv_seq: directed bench for conv_seq with N=2, IMG_H=4, PROC_LAT=2.
// Frame of 4 columns: FILL cycles 1-14 (chblk at 5 and 10), PROC 15-20,
// OUT 21-24, LOAD 25-28, PROC 29-34, OUT 35-38, DONE 39, o_done at 40
// (cycle 1 = first cycle after the edge that accepts i_start).
module tb_conv_seq;
   localparam int N        = 2;
   localparam int IMG_H    = 4;
   localparam int NB_ADDR  = 9;
   localparam int NB_COL   = 10;
   localparam int PROC_LAT = 2;
   localparam int PROC_LEN = 6;

   logic               clk = 1'b0;
   logic               rst;
   logic               i_start;
   logic [NB_COL-1:0]  i_ncols;
   logic               i_valid;
   logic               i_out_ready;
   logic               o_sop;
   logic               o_eop;
   logic               o_chblk;
   logic [NB_ADDR-1:0] o_addr;
   logic               o_in_ready;
   logic               o_out_valid;
   logic [NB_COL-1:0]  o_col_cnt;
   logic               o_busy;
   logic               o_done;
`ifdef CONV_SEQ_ABORT_EN
   logic               i_abort;
   logic               o_abort_ack;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int fill_acc, load_acc, chblk_n, proc_runs, xfer_n, done_n, done_cyc;

   conv_seq #(
      .N(N), .IMG_H(IMG_H), .NB_ADDR(NB_ADDR), .NB_COL(NB_COL), .PROC_LAT(PROC_LAT)
   ) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_ncols(i_ncols),
      .i_valid(i_valid), .i_out_ready(i_out_ready),
      .o_sop(o_sop), .o_eop(o_eop), .o_chblk(o_chblk), .o_addr(o_addr),
      .o_in_ready(o_in_ready), .o_out_valid(o_out_valid), .o_col_cnt(o_col_cnt),
      .o_busy(o_busy), .o_done(o_done)
`ifdef CONV_SEQ_ABORT_EN
      , .i_abort(i_abort), .o_abort_ack(o_abort_ack)
`endif
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_sop"}, o_sop, 0);
      chk({tag, "_eop"}, o_eop, 0);
      chk({tag, "_chblk"}, o_chblk, 0);
      chk({tag, "_addr"}, o_addr, 0);
      chk({tag, "_in_ready"}, o_in_ready, 0);
      chk({tag, "_out_valid"}, o_out_valid, 0);
      chk({tag, "_col_cnt"}, o_col_cnt, 0);
      chk({tag, "_busy"}, o_busy, 0);
      chk({tag, "_done"}, o_done, 0);
   endtask

   // mode: 0 plain, 1 toggle i_valid in FILL, 2 stall 5 cycles in OUT,
   // 3 stray i_start in PROC, 4 reset in PROC, 5 abort in second OUT.
   task automatic run_frame(input logic [NB_COL-1:0] nc, input int mode);
      int cyc, pc, col_acc, exp_addr, stall_left;
      logic [1:0] ph, prev_ph;
      logic prev_chblk, stalled, stop, vtog;
      fill_acc = 0; load_acc = 0; chblk_n = 0; proc_runs = 0;
      xfer_n = 0; done_n = 0; done_cyc = 0;
      cyc = 0; pc = 0; col_acc = 0; exp_addr = 0; stall_left = 0;
      prev_ph = 2'b00; prev_chblk = 1'b0; stalled = 1'b0; stop = 1'b0; vtog = 1'b1;
      i_ncols = nc; i_valid = 1'b1; i_out_ready = 1'b1; i_start = 1'b1;
      step();
      cyc = 1;
      while (!stop) begin
         i_start = 1'b0;
         ph = {o_eop, o_sop};
         if (ph == 2'b11) chk("phase_11", 32'(ph), 0);
         if (prev_ph == 2'b01 && ph != 2'b01) begin
            chk("proc_len", pc, PROC_LEN);
            proc_runs++;
         end
         if (ph == 2'b01) begin
            if (prev_ph != 2'b01) begin
               chk("acc_before_proc", col_acc, IMG_H);
               col_acc = 0; pc = 0; exp_addr = 0;
            end
            chk("proc_addr", o_addr, (pc < IMG_H) ? pc : IMG_H - 1);
            pc++;
            if (mode == 3 && proc_runs == 0 && pc == 2) begin
               i_start = 1'b1;
               i_ncols = 2;
            end
            if (mode == 4 && proc_runs == 0 && pc == 3) begin
               rst = 1'b1;
               #1;
               check_zero("rst_async");
               repeat (2) begin
                  step();
                  chk("rst_hold_done", o_done, 0);
                  chk("rst_hold_busy", o_busy, 0);
               end
               rst = 1'b0;
               stop = 1'b1;
            end
         end else if (ph == 2'b10) begin
            if (prev_ph != 2'b10) exp_addr = 0;
            chk("out_valid", o_out_valid, 1);
            chk("out_addr", o_addr, exp_addr);
`ifdef CONV_SEQ_ABORT_EN
            if (mode == 5 && proc_runs == 2 && exp_addr == 1) begin
               chk("pre_abort_col_cnt", o_col_cnt, 1);
               i_abort = 1'b1;
               step();
               i_abort = 1'b0;
               chk("abort_ack", o_abort_ack, 1);
               chk("abort_phase", 32'({o_eop, o_sop}), 0);
               chk("abort_busy", o_busy, 0);
               chk("abort_done", o_done, 0);
               chk("abort_col_cnt", o_col_cnt, 0);
               chk("abort_addr", o_addr, 0);
               step();
               chk("abort_ack_pulse", o_abort_ack, 0);
               chk("abort_done_after", o_done, 0);
               stop = 1'b1;
            end
`endif
            if (!stop) begin
               if (mode == 2 && proc_runs == 1 && exp_addr == 2 && !stalled) begin
                  stalled = 1'b1;
                  stall_left = 5;
               end
               if (stall_left > 0) begin
                  i_out_ready = 1'b0;
                  stall_left--;
               end else begin
                  i_out_ready = 1'b1;
               end
               if (o_out_valid && i_out_ready) begin
                  xfer_n++;
                  exp_addr = (exp_addr + 1) % IMG_H;
               end
            end
         end else if (o_in_ready || o_chblk) begin
            if (prev_ph != 2'b00) exp_addr = 0;
            chk("load_addr", o_addr, exp_addr);
            if (mode == 1 && proc_runs == 0) begin
               i_valid = vtog;
               vtog = !vtog;
            end else begin
               i_valid = 1'b1;
            end
            if (o_chblk) begin
               chk("chblk_after_4th", col_acc, IMG_H);
               chk("chblk_in_ready", o_in_ready, 0);
               chk("chblk_b2b", prev_chblk, 0);
               col_acc = 0;
               chblk_n++;
            end
            if (o_in_ready && i_valid) begin
               if (proc_runs == 0) fill_acc++;
               else load_acc++;
               col_acc++;
               exp_addr = (exp_addr + 1) % IMG_H;
            end
         end
         if (o_done) begin
            done_n++;
            done_cyc = cyc;
         end
         prev_ph = ph;
         prev_chblk = o_chblk;
         if (!stop) begin
            if (done_n > 0 && cyc >= done_cyc + 3) begin
               stop = 1'b1;
            end else if (cyc >= 300) begin
               chk("frame_timeout", cyc, 0);
               stop = 1'b1;
            end else begin
               step();
               cyc++;
            end
         end
      end
      i_valid = 1'b1;
      i_out_ready = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; i_start = 1'b0; i_ncols = '0; i_valid = 1'b0; i_out_ready = 1'b0;
`ifdef CONV_SEQ_ABORT_EN
      i_abort = 1'b0;
`endif
      repeat (2) step();
      check_zero("reset");
      rst = 1'b0;
      step();

      // Nominal 4-column frame.
      run_frame(10'd4, 0);
      chk("nom_fill_acc", fill_acc, 12);
      chk("nom_chblk", chblk_n, 2);
      chk("nom_proc_runs", proc_runs, 2);
      chk("nom_xfer", xfer_n, 8);
      chk("nom_load_acc", load_acc, 4);
      chk("nom_done_n", done_n, 1);
      chk("nom_done_cyc", done_cyc, 40);
      chk("nom_col_cnt", o_col_cnt, 2);
      chk("nom_busy_end", o_busy, 0);
      repeat (3) step();
      chk("col_cnt_hold", o_col_cnt, 2);

      // Too few columns: straight to DONE, no traffic; start clears col_cnt.
      i_ncols = 10'd2; i_start = 1'b1;
      step();
      i_start = 1'b0;
      chk("short_c1_phase", 32'({o_eop, o_sop}), 0);
      chk("short_c1_in_ready", o_in_ready, 0);
      chk("short_c1_chblk", o_chblk, 0);
      chk("short_c1_done", o_done, 0);
      chk("short_c1_busy", o_busy, 1);
      chk("short_c1_col_cnt", o_col_cnt, 0);
      step();
      chk("short_c2_done", o_done, 1);
      chk("short_c2_phase", 32'({o_eop, o_sop}), 0);
      chk("short_c2_in_ready", o_in_ready, 0);
      chk("short_c2_chblk", o_chblk, 0);
      chk("short_c2_busy", o_busy, 0);
      step();
      chk("short_c3_done", o_done, 0);
      step();

      // Alternating i_valid during FILL.
      run_frame(10'd4, 1);
      chk("tog_fill_acc", fill_acc, 12);
      chk("tog_chblk", chblk_n, 2);
      chk("tog_done_n", done_n, 1);
      chk("tog_col_cnt", o_col_cnt, 2);
      step();

      // Five-cycle consumer stall in the first OUT column.
      run_frame(10'd4, 2);
      chk("stall_xfer", xfer_n, 8);
      chk("stall_done_n", done_n, 1);
      chk("stall_done_cyc", done_cyc, 45);
      step();

      // Reset in the middle of PROC, then a full frame with a stray i_start.
      run_frame(10'd4, 4);
      chk("rst_frame_done_n", done_n, 0);
      step();
      check_zero("post_rst");
      run_frame(10'd4, 3);
      chk("rec_fill_acc", fill_acc, 12);
      chk("rec_load_acc", load_acc, 4);
      chk("rec_done_n", done_n, 1);
      chk("rec_done_cyc", done_cyc, 40);
      chk("rec_col_cnt", o_col_cnt, 2);
      step();

`ifdef CONV_SEQ_ABORT_EN
      // Abort during the second OUT column.
      run_frame(10'd4, 5);
      chk("abort_frame_done_n", done_n, 0);
      repeat (3) begin
         step();
         chk("abort_idle_done", o_done, 0);
         chk("abort_idle_busy", o_busy, 0);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
